// File: rtl/rob_pkg.sv
// Shared types and sizes for the reorder-buffer retirement slice.
// Retirement is in order; freed PRNs return to the rename free-PRN queue.
package rob_pkg;

    localparam int DEPTH        = 32;
    localparam int PRN_BITS     = 6;
    localparam int MAX_OPERANDS = 3;
    localparam int NUM_CMPL     = 2;
    localparam int TAG_BITS     = $clog2(DEPTH);

    // Pointer width: index bits plus one wrap bit.
    localparam int ROB_PTR      = TAG_BITS + 1;

    typedef struct packed {
        logic                                   valid;
        logic                                   done;
        logic [MAX_OPERANDS-1:0]                old_valid;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  old_prn;
    } RobEntry;

endpackage

// File: rtl/rob_perf_counters.sv
// Free-running 32-bit event counters for ROB retirement and full-stall events.
// They wrap at 2^32 and are cleared by the synchronous reset.
module rob_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_retire,
    input  logic        i_full_stall,
    output logic [31:0] o_perf_retired,
    output logic [31:0] o_perf_full_stall
);

    logic [31:0] r_retired;
    logic [31:0] r_full_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired    <= '0;
            r_full_stall <= '0;
        end else begin
            if (i_retire)     r_retired    <= r_retired + 32'd1;
            if (i_full_stall) r_full_stall <= r_full_stall + 32'd1;
        end
    end

    assign o_perf_retired    = r_retired;
    assign o_perf_full_stall = r_full_stall;

endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: one dispatch per cycle, completion broadcasts, and in-order retire with old-PRN free-back.
// Defining ROB_PERF_CNT_EN adds the retire and full-stall performance counters.
module rob_retire
    import rob_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_disp_valid,
    output logic                             o_disp_ready,
    input  logic [MAX_OPERANDS-1:0]          i_disp_old_valid,
    input  logic [MAX_OPERANDS*PRN_BITS-1:0] i_disp_old_prn,
    output logic [TAG_BITS-1:0]              o_disp_tag,
    input  logic [NUM_CMPL-1:0]              i_cmpl_valid,
    input  logic [NUM_CMPL*TAG_BITS-1:0]     i_cmpl_tag,
    output logic [MAX_OPERANDS-1:0]          o_free_valid,
    output logic [MAX_OPERANDS*PRN_BITS-1:0] o_free_prns,
    output logic                             o_retire_valid,
    output logic [TAG_BITS-1:0]              o_retire_tag,
    output logic [ROB_PTR-1:0]               o_count
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]                      o_perf_retired,
    output logic [31:0]                      o_perf_full_stall
`endif
);

    logic [ROB_PTR-1:0]  r_head;
    logic [ROB_PTR-1:0]  r_tail;
    RobEntry             r_entries [DEPTH];

    logic [TAG_BITS-1:0] w_head_idx;
    logic [TAG_BITS-1:0] w_tail_idx;
    logic                w_empty;
    logic                w_full;
    logic                w_retire;
    logic                w_disp_fire;
    RobEntry             w_head_entry;
    RobEntry             w_disp_entry;

    assign w_head_idx   = r_head[TAG_BITS-1:0];
    assign w_tail_idx   = r_tail[TAG_BITS-1:0];
    assign w_empty      = (r_head == r_tail);
    assign w_full       = (w_head_idx == w_tail_idx) && (r_head[TAG_BITS] != r_tail[TAG_BITS]);
    assign w_head_entry = r_entries[w_head_idx];

    // Ready looks only at registered occupancy, so a full ROB refuses dispatch even while retiring.
    assign w_disp_fire    = i_disp_valid && !w_full;
    assign w_retire       = !w_empty && w_head_entry.valid && w_head_entry.done;

    assign o_disp_ready   = !w_full;
    assign o_disp_tag     = w_tail_idx;
    assign o_retire_valid = w_retire;
    assign o_retire_tag   = w_head_idx;
    assign o_count        = r_tail - r_head;

    always_comb begin
        w_disp_entry           = '0;
        w_disp_entry.valid     = 1'b1;
        w_disp_entry.done      = 1'b0;
        w_disp_entry.old_valid = i_disp_old_valid;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            w_disp_entry.old_prn[i] = i_disp_old_prn[i*PRN_BITS +: PRN_BITS];
        end
    end

    always_comb begin
        o_free_valid = '0;
        o_free_prns  = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            o_free_valid[i] = w_retire && w_head_entry.old_valid[i];
            if (o_free_valid[i]) begin
                o_free_prns[i*PRN_BITS +: PRN_BITS] = w_head_entry.old_prn[i];
            end
        end
    end

    // NOTE: only valid/done are reset; the PRN payload is always rewritten at dispatch before it can be read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].done  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CMPL; k++) begin
                if (i_cmpl_valid[k] && r_entries[i_cmpl_tag[k*TAG_BITS +: TAG_BITS]].valid) begin
                    r_entries[i_cmpl_tag[k*TAG_BITS +: TAG_BITS]].done <= 1'b1;
                end
            end
            if (w_retire) begin
                r_entries[w_head_idx].valid <= 1'b0;
                r_entries[w_head_idx].done  <= 1'b0;
                r_head                      <= r_head + 1'b1;
            end
            // Last write wins: a dispatch always lands on a free slot, never the retiring head.
            if (w_disp_fire) begin
                r_entries[w_tail_idx] <= w_disp_entry;
                r_tail                <= r_tail + 1'b1;
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    rob_perf_counters u_perf (
        .clk               (clk),
        .rst               (rst),
        .i_retire          (w_retire),
        .i_full_stall      (i_disp_valid && w_full),
        .o_perf_retired    (o_perf_retired),
        .o_perf_full_stall (o_perf_full_stall)
    );
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Self-checking bench for rob_retire: directed scenarios plus randomized traffic against a queue model.
// Perf-counter checks are compiled in when ROB_PERF_CNT_EN is defined.
module tb_rob_retire;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [2:0]  disp_old_valid = '0;
    logic [17:0] disp_old_prn = '0;
    logic [4:0]  disp_tag;
    logic [1:0]  cmpl_valid = '0;
    logic [9:0]  cmpl_tag = '0;
    logic [2:0]  free_valid;
    logic [17:0] free_prns;
    logic        retire_valid;
    logic [4:0]  retire_tag;
    logic [5:0]  count;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_full_stall;
`endif

    always #5 clk = ~clk;

    rob_retire dut (
        .clk              (clk),
        .rst              (rst),
        .i_disp_valid     (disp_valid),
        .o_disp_ready     (disp_ready),
        .i_disp_old_valid (disp_old_valid),
        .i_disp_old_prn   (disp_old_prn),
        .o_disp_tag       (disp_tag),
        .i_cmpl_valid     (cmpl_valid),
        .i_cmpl_tag       (cmpl_tag),
        .o_free_valid     (free_valid),
        .o_free_prns      (free_prns),
        .o_retire_valid   (retire_valid),
        .o_retire_tag     (retire_tag),
        .o_count          (count)
`ifdef ROB_PERF_CNT_EN
        ,
        .o_perf_retired   (perf_retired),
        .o_perf_full_stall(perf_full_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: program-order queue of in-flight tags plus per-tag payload.
    int         q[$];
    bit         m_done[32];
    bit         m_inflight[32];
    logic [2:0] m_ov[32];
    logic [5:0] m_op[32][3];
    int         m_next = 0;
    int unsigned m_retired = 0;
    int unsigned m_stall = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            for (int t = 0; t < 32; t++) begin
                m_done[t] = 0;
                m_inflight[t] = 0;
            end
            m_next = 0;
            m_retired = 0;
            m_stall = 0;
        end else begin
            automatic bit ready = (q.size() < 32);
            automatic bit ret = (q.size() > 0) && m_done[q[0]];
            if (ret) m_retired++;
            if (disp_valid && !ready) m_stall++;
            for (int k = 0; k < 2; k++) begin
                automatic int t = int'(cmpl_tag[k*5 +: 5]);
                if (cmpl_valid[k] && m_inflight[t]) m_done[t] = 1;
            end
            if (ret) begin
                automatic int t = q.pop_front();
                m_inflight[t] = 0;
                m_done[t] = 0;
            end
            if (disp_valid && ready) begin
                q.push_back(m_next);
                m_inflight[m_next] = 1;
                m_done[m_next] = 0;
                m_ov[m_next] = disp_old_valid;
                for (int i = 0; i < 3; i++) m_op[m_next][i] = disp_old_prn[i*6 +: 6];
                m_next = (m_next + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            automatic bit rv = (q.size() > 0) && m_done[q[0]];
            automatic int rtag = (q.size() > 0) ? q[0] : m_next;
            check("count", 32'(count), 32'(q.size()));
            check("disp_ready", 32'(disp_ready), 32'(q.size() < 32));
            check("disp_tag", 32'(disp_tag), 32'(m_next));
            check("retire_valid", 32'(retire_valid), 32'(rv));
            check("retire_tag", 32'(retire_tag), 32'(rtag));
            for (int i = 0; i < 3; i++) begin
                automatic bit fv = rv && m_ov[rtag][i];
                check("free_valid", 32'(free_valid[i]), 32'(fv));
                check("free_prn", 32'(free_prns[i*6 +: 6]), fv ? 32'(m_op[rtag][i]) : 32'd0);
            end
`ifdef ROB_PERF_CNT_EN
            check("perf_retired", perf_retired, m_retired);
            check("perf_full_stall", perf_full_stall, m_stall);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        cmpl_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_disp(input logic [2:0] ov, input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2);
        disp_valid     = 1'b1;
        disp_old_valid = ov;
        disp_old_prn   = {p2, p1, p0};
    endtask

    task automatic set_rand_disp();
        set_disp(3'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic set_cmpl(input int port, input int tag);
        cmpl_valid[port]        = 1'b1;
        cmpl_tag[port*5 +: 5]   = 5'(tag);
    endtask

    initial begin
        // 1: single entry round trip with hand-computed free-back.
        do_reset();
        check("rst_ready", 32'(disp_ready), 1);
        check("rst_disp_tag", 32'(disp_tag), 0);
        check("rst_retire_valid", 32'(retire_valid), 0);
        check("rst_free_valid", 32'(free_valid), 0);
        check("rst_free_prns", 32'(free_prns), 0);
        check("rst_retire_tag", 32'(retire_tag), 0);
        check("rst_count", 32'(count), 0);
        set_disp(3'b101, 6'd7, 6'd0, 6'd9);
        tick();
        check("t1_no_retire_yet", 32'(retire_valid), 0);
        check("t1_count", 32'(count), 1);
        set_cmpl(0, 0);
        tick();
        check("t1_retire_valid", 32'(retire_valid), 1);
        check("t1_free_valid", 32'(free_valid), 32'b101);
        check("t1_prn0", 32'(free_prns[5:0]), 7);
        check("t1_prn1", 32'(free_prns[11:6]), 0);
        check("t1_prn2", 32'(free_prns[17:12]), 9);
        check("t1_retire_tag", 32'(retire_tag), 0);
        tick();
        check("t1_empty", 32'(count), 0);

        // 2: out-of-order completion, in-order retire.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            set_rand_disp();
            tick();
        end
        set_cmpl(0, 2);
        tick();
        check("t2_wait_a", 32'(retire_valid), 0);
        set_cmpl(1, 1);
        tick();
        check("t2_wait_b", 32'(retire_valid), 0);
        set_cmpl(0, 0);
        tick();
        for (int n = 0; n < 3; n++) begin
            check("t2_rv", 32'(retire_valid), 1);
            check("t2_tag", 32'(retire_tag), 32'(n));
            tick();
        end
        check("t2_done", 32'(retire_valid), 0);

        // 3: full ROB, no bypass from the same-cycle retire, then wrap to tag 0.
        do_reset();
        for (int n = 0; n < 32; n++) begin
            set_rand_disp();
            tick();
        end
        check("t3_count_full", 32'(count), 32);
        check("t3_ready_full", 32'(disp_ready), 0);
        set_rand_disp();
        set_cmpl(0, 0);
        tick();
        check("t3_retire", 32'(retire_valid), 1);
        check("t3_ready_during_retire", 32'(disp_ready), 0);
        tick();
        check("t3_ready_after", 32'(disp_ready), 1);
        check("t3_disp_tag_wrap", 32'(disp_tag), 0);
        check("t3_count_after", 32'(count), 31);

        // 4: steady state, one dispatch and one retire per cycle.
        do_reset();
        for (int n = 0; n < 102; n++) begin
            set_rand_disp();
            if (n >= 1) set_cmpl(0, (n - 1) % 32);
            tick();
            if (n >= 1) begin
                check("t4_count", 32'(count), 2);
                check("t4_rv", 32'(retire_valid), 1);
                check("t4_tag", 32'(retire_tag), 32'((n - 1) % 32));
            end
        end
        set_cmpl(0, 101 % 32);
        tick();
        tick();
        tick();

        // 5: duplicate completion tags and a completion to an unused slot.
        do_reset();
        set_rand_disp();
        tick();
        set_rand_disp();
        tick();
        set_cmpl(0, 1);
        set_cmpl(1, 1);
        tick();
        check("t5_no_retire_a", 32'(retire_valid), 0);
        set_cmpl(0, 5);
        tick();
        check("t5_no_retire_b", 32'(retire_valid), 0);
        check("t5_count", 32'(count), 2);
        set_cmpl(0, 0);
        tick();
        check("t5_ret0", 32'(retire_tag), 0);
        check("t5_rv0", 32'(retire_valid), 1);
        tick();
        check("t5_ret1", 32'(retire_tag), 1);
        check("t5_rv1", 32'(retire_valid), 1);
        tick();
        for (int n = 0; n < 4; n++) begin
            set_rand_disp();
            tick();
        end
        tick();
        tick();
        check("t5_no_spurious", 32'(retire_valid), 0);
        check("t5_count_end", 32'(count), 4);

        // 6: reset with entries in flight.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            set_rand_disp();
            if (n >= 2) set_cmpl(0, n - 2);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_count", 32'(count), 0);
        check("t6_free_valid", 32'(free_valid), 0);
        check("t6_ready", 32'(disp_ready), 1);
        check("t6_rv", 32'(retire_valid), 0);
        check("t6_disp_tag", 32'(disp_tag), 0);
`ifdef ROB_PERF_CNT_EN
        check("t6_perf_retired", perf_retired, 0);
        check("t6_perf_stall", perf_full_stall, 0);
`endif

        // Randomized traffic in phases of differing pressure.
        do_reset();
        for (int phase = 0; phase < 3; phase++) begin
            automatic int pd = (phase == 0) ? 85 : (phase == 1) ? 40 : 65;
            automatic int pc = (phase == 0) ? 25 : (phase == 1) ? 70 : 45;
            for (int n = 0; n < 1000; n++) begin
                automatic bit dv = ($urandom % 100) < pd;
                if (dv) set_rand_disp();
                for (int k = 0; k < 2; k++) begin
                    if (($urandom % 100) < pc) begin
                        automatic int t = int'($urandom % 32);
                        if (dv && q.size() < 32 && t == m_next) t = (t + 1) % 32;
                        set_cmpl(k, t);
                    end
                end
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
